// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared constants, state encoding and helpers for the FFT sequencer
// Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int N     = 16;
    localparam int LOG2N = 4;
    localparam int LAT   = 2;

    // Stages 0 and 2 apply the >>>1 scaling.
    localparam logic [LOG2N-1:0] SCALE_STAGE = 4'b0101;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        UNLOAD  = 3'd4
    } state_e;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : fft_addr_gen
// Brief    : Butterfly (stage, index) to operand address pair and twiddle index
// Revision : 1.0
// ============================================================================
module fft_addr_gen
    import fft_pkg::*;
(
    input  logic [1:0]       s,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw
);

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] tw_full;

    always_comb begin
        k_ext   = {1'b0, k};
        span    = LOG2N'(1) << s;
        pos     = k_ext & (span - LOG2N'(1));
        grp     = k_ext >> s;
        // Each group covers 2*span words; the bottom operand sits span above the top.
        addr_a  = (grp << ({1'b0, s} + 3'd1)) | pos;
        addr_b  = addr_a | span;
        tw_full = pos << (2'(LOG2N-1) - s);
        tw      = tw_full[LOG2N-2:0];
    end

endmodule
`default_nettype wire

// File: rtl/fft_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_ctrl
// Brief    : Load / compute / unload sequencer for an in-place 16-point DIT FFT
// Revision : 1.0
// ============================================================================
module fft_ctrl
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ld_we,
    output logic [LOG2N-1:0] ld_addr,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic [1:0]       stage_idx,
    output logic             scale_en,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    state_e                      state_q, state_d;
    logic [LOG2N-1:0]            cnt_q, cnt_d;
    logic [1:0]                  s_q, s_d;
    logic [LOG2N-2:0]            k_q, k_d;
    logic [DW-1:0]               dr_q, dr_d;
    logic [LOG2N:0]              u_q, u_d;
    logic [LOG2N:0]              h_q, h_d;
    logic                        ov_q, ov_d;
    logic                        done_q, done_d;
    logic [LAT-1:0]              en_dl_q, en_dl_d;
    logic [LAT-1:0][LOG2N-1:0]   a_dl_q, a_dl_d;
    logic [LAT-1:0][LOG2N-1:0]   b_dl_q, b_dl_d;

    logic [LOG2N-1:0]            ag_a, ag_b;
    logic [LOG2N-2:0]            ag_tw;
    logic                        hs;

    fft_addr_gen u_addr_gen (
        .s      (s_q),
        .k      (k_q),
        .addr_a (ag_a),
        .addr_b (ag_b),
        .tw     (ag_tw)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        k_d       = k_q;
        dr_d      = dr_q;
        u_d       = u_q;
        h_d       = h_q;
        ov_d      = ov_q;
        done_d    = 1'b0;
        busy      = (state_q != IDLE);
        in_ready  = (state_q == LOAD);
        ld_we     = in_valid & in_ready;
        ld_addr   = bitrev(cnt_q);
        rd_en     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_idx    = '0;
        stage_idx = '0;
        scale_en  = 1'b0;
        hs        = ov_q & out_ready;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (ld_we) begin
                    cnt_d = cnt_q + LOG2N'(1);
                    if (cnt_q == LOG2N'(N-1)) begin
                        state_d = COMPUTE;
                        s_d     = '0;
                        k_d     = '0;
                    end
                end
            end
            COMPUTE: begin
                rd_en     = 1'b1;
                rd_addr_a = ag_a;
                rd_addr_b = ag_b;
                tw_idx    = ag_tw;
                stage_idx = s_q;
                scale_en  = SCALE_STAGE[s_q];
                k_d       = k_q + (LOG2N-1)'(1);
                if (k_q == (LOG2N-1)'(N/2-1)) begin
                    state_d = DRAIN;
                    dr_d    = '0;
                end
            end
            DRAIN: begin
                // Hold off reads until the current stage's write-backs have landed.
                dr_d = dr_q + DW'(1);
                if (dr_q == DW'(LAT-1)) begin
                    dr_d = '0;
                    if (s_q != 2'(LOG2N-1)) begin
                        s_d     = s_q + 2'd1;
                        k_d     = '0;
                        state_d = COMPUTE;
                    end else begin
                        s_d     = '0;
                        u_d     = '0;
                        h_d     = '0;
                        state_d = UNLOAD;
                    end
                end
            end
            UNLOAD: begin
                rd_addr_a = u_q[LOG2N-1:0];
                rd_en     = (u_q < (LOG2N+1)'(N)) && (!ov_q || out_ready);
                if (rd_en) begin
                    u_d  = u_q + (LOG2N+1)'(1);
                    ov_d = 1'b1;
                end else if (hs) begin
                    ov_d = 1'b0;
                end
                if (hs) begin
                    h_d = h_q + (LOG2N+1)'(1);
                    if (h_q == (LOG2N+1)'(N-1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        u_d     = '0;
                        h_d     = '0;
                        ov_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Write-back delay lines track the read strobe in every state.
        en_dl_d[0] = rd_en;
        a_dl_d[0]  = rd_addr_a;
        b_dl_d[0]  = rd_addr_b;
        for (int i = 1; i < LAT; i++) begin
            en_dl_d[i] = en_dl_q[i-1];
            a_dl_d[i]  = a_dl_q[i-1];
            b_dl_d[i]  = b_dl_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            k_q     <= '0;
            dr_q    <= '0;
            u_q     <= '0;
            h_q     <= '0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
            en_dl_q <= '0;
            a_dl_q  <= '0;
            b_dl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            k_q     <= k_d;
            dr_q    <= dr_d;
            u_q     <= u_d;
            h_q     <= h_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
            en_dl_q <= en_dl_d;
            a_dl_q  <= a_dl_d;
            b_dl_q  <= b_dl_d;
        end
    end

    assign done      = done_q;
    assign out_valid = ov_q;
    assign wr_en     = en_dl_q[LAT-1];
    assign wr_addr_a = a_dl_q[LAT-1];
    assign wr_addr_b = b_dl_q[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_fft_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_ctrl
// Brief    : Self-checking bench: RAM/butterfly model driven by fft_ctrl, DFT reference
// Revision : 1.0
// ============================================================================
module tb_fft_ctrl;

    localparam int  NP = 16;
    localparam real PI = 3.14159265358979323846;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       busy, done, in_ready, ld_we, rd_en, scale_en, wr_en, out_valid;
    logic [3:0] ld_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [2:0] tw_idx;
    logic [1:0] stage_idx;

    fft_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .stage_idx (stage_idx),
        .scale_en  (scale_en),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_int(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_real(input string tag, input real obs, input real exp);
        checks++;
        assert ((obs - exp) < 0.01 && (exp - obs) < 0.01) else begin
            failures++;
            $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
        end
    endtask

    function automatic int tb_bitrev(input int v);
        int r = 0;
        for (int b = 0; b < 4; b++) if ((v >> b) & 1) r += (8 >> b);
        return r;
    endfunction

    // Behavioural sample RAM + registered butterfly, driven by the DUT's strobes
    real  x_re[NP];
    real  mem_re[NP], mem_im[NP];
    real  p1_ar, p1_ai, p1_br, p1_bi, p2_ar, p2_ai, p2_br, p2_bi;
    int   p1_tw;
    bit   p1_sc;
    real  dout_re, dout_im;
    int   dout_addr;
    real  ra_r, ra_i, rb_r, rb_i, w_r, w_i, t_r, t_i;
    int   ld_q[$], rda_q[$], rdb_q[$], tw_q[$], st_q[$], sc_q[$], rdc_q[$];
    real  o_re[$], o_im[$];
    int   o_addr[$];
    int   n_rd, done_cnt, first_ov, cyc;
    bit   ld16_pend, pv_ov, pv_rdy;
    logic [3:0] pv_ra;
    logic       h_en[2];
    logic [3:0] h_a[2], h_b[2];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            h_en[0] = 1'b0; h_en[1] = 1'b0;
            h_a[0] = '0; h_a[1] = '0; h_b[0] = '0; h_b[1] = '0;
            p1_ar = 0.0; p1_ai = 0.0; p1_br = 0.0; p1_bi = 0.0; p1_tw = 0; p1_sc = 1'b0;
            p2_ar = 0.0; p2_ai = 0.0; p2_br = 0.0; p2_bi = 0.0;
            pv_ov = 1'b0; pv_rdy = 1'b0; pv_ra = '0; ld16_pend = 1'b0;
        end else begin
            check_int("wr_en_delay", wr_en, h_en[1]);
            check_int("wr_addr_a_delay", wr_addr_a, h_a[1]);
            check_int("wr_addr_b_delay", wr_addr_b, h_b[1]);
            if (ld16_pend) begin
                check_int("in_ready_drop", in_ready, 0);
                ld16_pend = 1'b0;
            end
            if (ld_we) begin
                ld_q.push_back(int'(ld_addr));
                if (ld_q.size() <= NP) begin
                    mem_re[ld_addr] = x_re[ld_q.size()-1];
                    mem_im[ld_addr] = 0.0;
                end
                if (ld_q.size() == NP) ld16_pend = 1'b1;
            end
            if (pv_ov && !pv_rdy) begin
                check_int("ov_hold", out_valid, 1);
                check_int("stall_addr", rd_addr_a, pv_ra);
            end
            if (out_valid && !out_ready) check_int("stall_no_rd", rd_en, 0);
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                o_re.push_back(dout_re); o_im.push_back(dout_im); o_addr.push_back(dout_addr);
            end
            if (done) begin
                done_cnt++;
                check_int("busy_low_at_done", busy, 0);
            end
            ra_r = mem_re[rd_addr_a]; ra_i = mem_im[rd_addr_a];
            rb_r = mem_re[rd_addr_b]; rb_i = mem_im[rd_addr_b];
            if (rd_en) begin
                if (n_rd < 32) begin
                    rda_q.push_back(int'(rd_addr_a)); rdb_q.push_back(int'(rd_addr_b));
                    tw_q.push_back(int'(tw_idx)); st_q.push_back(int'(stage_idx));
                    sc_q.push_back(int'(scale_en)); rdc_q.push_back(cyc);
                end
                n_rd++;
            end
            if (wr_en) begin
                mem_re[wr_addr_a] = p2_ar; mem_im[wr_addr_a] = p2_ai;
                mem_re[wr_addr_b] = p2_br; mem_im[wr_addr_b] = p2_bi;
            end
            w_r = $cos(2.0 * PI * p1_tw / NP);
            w_i = -$sin(2.0 * PI * p1_tw / NP);
            t_r = w_r * p1_br - w_i * p1_bi;
            t_i = w_r * p1_bi + w_i * p1_br;
            p2_ar = p1_ar + t_r; p2_ai = p1_ai + t_i;
            p2_br = p1_ar - t_r; p2_bi = p1_ai - t_i;
            if (p1_sc) begin
                p2_ar = p2_ar / 2.0; p2_ai = p2_ai / 2.0; p2_br = p2_br / 2.0; p2_bi = p2_bi / 2.0;
            end
            if (rd_en) begin
                p1_ar = ra_r; p1_ai = ra_i; p1_br = rb_r; p1_bi = rb_i;
                p1_tw = int'(tw_idx); p1_sc = scale_en;
                dout_re = ra_r; dout_im = ra_i; dout_addr = int'(rd_addr_a);
            end
            h_en[1] = h_en[0]; h_a[1] = h_a[0]; h_b[1] = h_b[0];
            h_en[0] = rd_en;   h_a[0] = rd_addr_a; h_b[0] = rd_addr_b;
            pv_ov = out_valid; pv_rdy = out_ready; pv_ra = rd_addr_a;
        end
    end

    task automatic new_frame();
        ld_q.delete(); rda_q.delete(); rdb_q.delete(); tw_q.delete(); st_q.delete();
        sc_q.delete(); rdc_q.delete(); o_re.delete(); o_im.delete(); o_addr.delete();
        n_rd = 0; done_cnt = 0; first_ov = -1;
    endtask

    task automatic check_outputs_zero();
        check_int("reset_ctrl", {busy, done, in_ready, ld_we, rd_en, scale_en, wr_en, out_valid}, 0);
        check_int("reset_addr", {ld_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, tw_idx, stage_idx}, 0);
    endtask

    task automatic run_frame(input int vmode, input int rmode, input bit spam,
                             input bit abort, output bit aborted);
        int pat[7] = '{1, 1, 0, 0, 1, 0, 1};
        int rk = 0;
        bit fin = 1'b0;
        aborted = 1'b0;
        new_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 600; c++) begin
            in_valid = (vmode == 0) ? (c % 2 == 0) : ($urandom_range(0, 2) != 0);
            if (rmode == 0) out_ready = 1'b1;
            else if (out_valid) begin
                out_ready = (rk < 7) ? pat[rk][0] : 1'($urandom_range(0, 1));
                rk++;
            end else out_ready = 1'($urandom_range(0, 1));
            start = spam && busy && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (abort && rd_en && stage_idx == 2'd2 && rd_addr_a == 4'd9) begin
                aborted = 1'b1;
                break;
            end
            if (done_cnt > 0) begin
                fin = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; in_valid = 1'b0;
        check_int("frame_terminates", fin | aborted, 1);
        if (fin) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            check_int("done_once", done_cnt, 1);
            check_int("idle_after_done", busy, 0);
        end
    endtask

    task automatic check_frame(input bit chk_latency);
        int   idx = 0;
        real  er, ei;
        check_int("ld_count", ld_q.size(), NP);
        for (int i = 0; i < NP && i < ld_q.size(); i++) check_int("ld_addr_bitrev", ld_q[i], tb_bitrev(i));
        check_int("compute_reads", rda_q.size(), 32);
        for (int s = 0; s < 4; s++) begin
            int span = 1 << s;
            for (int a = 0; a < NP; a++) begin
                if ((a & span) == 0) begin
                    if (idx < rda_q.size()) begin
                        check_int("rd_addr_a", rda_q[idx], a);
                        check_int("rd_addr_b", rdb_q[idx], a + span);
                        check_int("tw_idx", tw_q[idx], (a % span) * (8 / span));
                        check_int("stage_idx", st_q[idx], s);
                        check_int("scale_en", sc_q[idx], (s % 2 == 0) ? 1 : 0);
                        check_int("read_timing", rdc_q[idx] - rdc_q[0], s * 10 + (idx % 8));
                    end
                    idx++;
                end
            end
        end
        if (chk_latency && rdc_q.size() > 0) check_int("first_out_valid", first_ov - rdc_q[0], 41);
        check_int("out_count", o_re.size(), NP);
        for (int k = 0; k < NP && k < o_re.size(); k++) begin
            er = 0.0; ei = 0.0;
            for (int n = 0; n < NP; n++) begin
                er += x_re[n] * $cos(2.0 * PI * n * k / NP);
                ei -= x_re[n] * $sin(2.0 * PI * n * k / NP);
            end
            check_int("out_order", o_addr[k], k);
            check_real("out_re", o_re[k], er / 4.0);
            check_real("out_im", o_im[k], ei / 4.0);
        end
    endtask

    initial begin
        bit ab;
        cyc = 0;
        new_frame();
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero();
        in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Impulse, in_valid toggling, out_ready held high
        for (int i = 0; i < NP; i++) x_re[i] = (i == 0) ? 1000.0 : 0.0;
        run_frame(0, 0, 1'b0, 1'b0, ab);
        check_frame(1'b1);

        // Random data, backpressure, stray start pulses
        for (int i = 0; i < NP; i++) x_re[i] = real'(int'($urandom_range(0, 1000)) - 500);
        run_frame(1, 1, 1'b1, 1'b0, ab);
        check_frame(1'b0);

        // Asynchronous reset in stage 2, butterfly 5
        for (int i = 0; i < NP; i++) x_re[i] = real'(int'($urandom_range(0, 1000)) - 500);
        run_frame(1, 0, 1'b1, 1'b1, ab);
        check_int("reached_s2_k5", ab, 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero();
        @(posedge clk); #1;
        check_outputs_zero();
        rst_n = 1'b1;

        for (int i = 0; i < NP; i++) x_re[i] = real'(int'($urandom_range(0, 1000)) - 500);
        run_frame(1, 0, 1'b1, 1'b0, ab);
        check_frame(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
